// File: rtl/hazard_tracker_pkg.sv
// Shared types and nearest-producer search for the D/E/M hazard unit.
// Slot fields are sized to the widest supported configuration; narrower ports zero-extend.
package hazard_tracker_pkg;

  localparam int AW_MAX = 8;
  localparam int TW_MAX = 4;

  localparam logic [1:0] FW_NONE = 2'd0;
  localparam logic [1:0] FW_M    = 2'd1;
  localparam logic [1:0] FW_W    = 2'd2;
  localparam logic [1:0] FW_E    = 2'd3;

  typedef struct packed {
    logic [AW_MAX-1:0] a1;
    logic [AW_MAX-1:0] a2;
    logic [AW_MAX-1:0] a3;
    logic              regwe;
    logic [TW_MAX-1:0] tnew;
    logic              md_start;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  typedef struct packed {
    logic              hit;
    logic [1:0]        sel;
    logic [TW_MAX-1:0] tnew;
  } match_t;

  function automatic logic produces(input slot_t s, input logic [AW_MAX-1:0] x);
    return s.regwe && (s.a3 == x) && (x != '0);
  endfunction

  // Candidates are given nearest first; a code of FW_NONE marks a slot that is not searched.
  function automatic match_t nearest(input logic [AW_MAX-1:0] x,
                                     input slot_t s0, input logic [1:0] c0,
                                     input slot_t s1, input logic [1:0] c1,
                                     input slot_t s2, input logic [1:0] c2);
    match_t m;
    m = '0;
    if (c2 != FW_NONE && produces(s2, x)) begin
      m.hit = 1'b1; m.sel = c2; m.tnew = s2.tnew;
    end
    if (c1 != FW_NONE && produces(s1, x)) begin
      m.hit = 1'b1; m.sel = c1; m.tnew = s1.tnew;
    end
    if (c0 != FW_NONE && produces(s0, x)) begin
      m.hit = 1'b1; m.sel = c0; m.tnew = s0.tnew;
    end
    return m;
  endfunction

  function automatic logic [1:0] fw_sel(input match_t m);
    return (m.hit && m.tnew == '0) ? m.sel : FW_NONE;
  endfunction

  function automatic logic needs_stall(input match_t m, input logic [TW_MAX-1:0] tuse);
    return m.hit && (m.tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// One pipeline tracking slot; optionally ages tnew by one (saturating) as it loads.
// Reset clears to a bubble.
module hazard_slot_reg
  import hazard_tracker_pkg::*;
#(
  parameter bit DEC_ON_LOAD = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  input  slot_t d,
  output slot_t q
);

  slot_t d_aged;

  always_comb begin
    d_aged = d;
    if (DEC_ON_LOAD && d.tnew != '0) d_aged.tnew = d.tnew - TW_MAX'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) q <= SLOT_BUBBLE;
    else       q <= d_aged;
  end

endmodule

// File: rtl/hazard_tracker.sv
// Tracks E/M/W producers, drives all forwarding selects and the D-stage stall,
// and holds HI/LO users while the mult/div unit is busy.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int TW     = 2,
  parameter int MD_LAT = 5,
  parameter int MD_CW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_a1,
  input  logic [REG_AW-1:0] id_a2,
  input  logic [TW-1:0]     id_tuse1,
  input  logic [TW-1:0]     id_tuse2,
  input  logic [REG_AW-1:0] id_a3,
  input  logic [TW-1:0]     id_tnew,
  input  logic              id_regwe,
  input  logic              id_md_use,
  input  logic              id_md_start,
  output logic              stall,
  output logic [1:0]        d1_fw,
  output logic [1:0]        d2_fw,
  output logic [1:0]        e1_fw,
  output logic [1:0]        e2_fw,
  output logic [1:0]        m1_fw,
  output logic [1:0]        m2_fw,
  output logic              md_busy
);

  slot_t d_slot, e_q, m_q, w_q;
  logic [MD_CW-1:0] md_cnt;
  logic [AW_MAX-1:0] a1_x, a2_x;
  match_t md1, md2, me1, me2, mm1, mm2;
  logic unused_fields;

  assign a1_x = AW_MAX'(id_a1);
  assign a2_x = AW_MAX'(id_a2);

  // D operands search E, M, W; E operands search M, W; M operands only W.
  always_comb begin
    md1 = nearest(a1_x,   e_q, FW_E, m_q, FW_M,    w_q,         FW_W);
    md2 = nearest(a2_x,   e_q, FW_E, m_q, FW_M,    w_q,         FW_W);
    me1 = nearest(e_q.a1, m_q, FW_M, w_q, FW_W,    SLOT_BUBBLE, FW_NONE);
    me2 = nearest(e_q.a2, m_q, FW_M, w_q, FW_W,    SLOT_BUBBLE, FW_NONE);
    mm1 = nearest(m_q.a1, w_q, FW_W, SLOT_BUBBLE, FW_NONE, SLOT_BUBBLE, FW_NONE);
    mm2 = nearest(m_q.a2, w_q, FW_W, SLOT_BUBBLE, FW_NONE, SLOT_BUBBLE, FW_NONE);
  end

  assign d1_fw = fw_sel(md1);
  assign d2_fw = fw_sel(md2);
  assign e1_fw = fw_sel(me1);
  assign e2_fw = fw_sel(me2);
  assign m1_fw = fw_sel(mm1);
  assign m2_fw = fw_sel(mm2);

  assign md_busy = (md_cnt != '0) || e_q.md_start;

  assign stall = needs_stall(md1, TW_MAX'(id_tuse1))
               | needs_stall(md2, TW_MAX'(id_tuse2))
               | (id_md_use && md_busy);

  always_comb begin
    d_slot = SLOT_BUBBLE;
    if (!stall) begin
      d_slot.a1       = a1_x;
      d_slot.a2       = a2_x;
      d_slot.a3       = AW_MAX'(id_a3);
      d_slot.regwe    = id_regwe;
      d_slot.tnew     = TW_MAX'(id_tnew);
      d_slot.md_start = id_md_start;
    end
  end

  // tnew is counted from E, so the D->E load does not age it.
  hazard_slot_reg #(.DEC_ON_LOAD(1'b0)) u_slot_e (.clk(clk), .reset(reset), .d(d_slot), .q(e_q));
  hazard_slot_reg #(.DEC_ON_LOAD(1'b1)) u_slot_m (.clk(clk), .reset(reset), .d(e_q),    .q(m_q));
  hazard_slot_reg #(.DEC_ON_LOAD(1'b1)) u_slot_w (.clk(clk), .reset(reset), .d(m_q),    .q(w_q));

  always_ff @(posedge clk) begin
    if (reset)                md_cnt <= '0;
    else if (e_q.md_start)    md_cnt <= MD_CW'(MD_LAT);
    else if (md_cnt != '0)    md_cnt <= md_cnt - MD_CW'(1);
  end

  assign unused_fields = ^{w_q.a1, w_q.a2, w_q.md_start, m_q.md_start};

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboard bench: stimulus pushes predicted outputs, a negedge monitor pops and compares.
module tb_hazard_tracker;
  localparam int REG_AW = 5;
  localparam int TW     = 2;
  localparam int MD_LAT = 5;
  localparam int MD_CW  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [REG_AW-1:0] id_a1 = '0, id_a2 = '0, id_a3 = '0;
  logic [TW-1:0] id_tuse1 = '0, id_tuse2 = '0, id_tnew = '0;
  logic id_regwe = 1'b0, id_md_use = 1'b0, id_md_start = 1'b0;
  logic stall, md_busy;
  logic [1:0] d1_fw, d2_fw, e1_fw, e2_fw, m1_fw, m2_fw;

  always #5 clk = ~clk;

  hazard_tracker #(.REG_AW(REG_AW), .TW(TW), .MD_LAT(MD_LAT), .MD_CW(MD_CW)) dut (
    .clk(clk), .reset(reset),
    .id_a1(id_a1), .id_a2(id_a2), .id_tuse1(id_tuse1), .id_tuse2(id_tuse2),
    .id_a3(id_a3), .id_tnew(id_tnew), .id_regwe(id_regwe),
    .id_md_use(id_md_use), .id_md_start(id_md_start),
    .stall(stall), .d1_fw(d1_fw), .d2_fw(d2_fw), .e1_fw(e1_fw), .e2_fw(e2_fw),
    .m1_fw(m1_fw), .m2_fw(m2_fw), .md_busy(md_busy)
  );

  typedef struct packed {
    logic stall;
    logic [1:0] d1, d2, e1, e2, m1, m2;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int passed = 0;

  // Reference model: index 0 = instruction in E, 1 = in M, 2 = in W.
  typedef struct {
    int a1, a2, a3, tnew;
    bit we, md;
  } rec_t;
  rec_t pipe[3];
  bit   occ[3];
  int   cyc = 0;
  int   md_free = 0;

  function automatic void chk(string name, int act, int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endfunction

  function automatic int tnow(int i);
    int t;
    t = pipe[i].tnew - i;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic int near(int start, int x);
    for (int i = start; i < 3; i++)
      if (occ[i] && pipe[i].we && pipe[i].a3 == x && x != 0) return i;
    return -1;
  endfunction

  function automatic int fwd(int i);
    if (i < 0 || tnow(i) != 0) return 0;
    return (i == 0) ? 3 : (i == 1) ? 1 : 2;
  endfunction

  function automatic bit op_stall(int i, int tuse);
    return (i >= 0) && (tnow(i) > tuse);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int ea1, ea2, ma1, ma2;
    bit busy;
    ea1 = occ[0] ? pipe[0].a1 : 0;
    ea2 = occ[0] ? pipe[0].a2 : 0;
    ma1 = occ[1] ? pipe[1].a1 : 0;
    ma2 = occ[1] ? pipe[1].a2 : 0;
    busy = (occ[0] && pipe[0].md) || (cyc < md_free);
    e.d1 = 2'(fwd(near(0, int'(id_a1))));
    e.d2 = 2'(fwd(near(0, int'(id_a2))));
    e.e1 = 2'(fwd(near(1, ea1)));
    e.e2 = 2'(fwd(near(1, ea2)));
    e.m1 = 2'(fwd(near(2, ma1)));
    e.m2 = 2'(fwd(near(2, ma2)));
    e.busy = busy;
    e.stall = op_stall(near(0, int'(id_a1)), int'(id_tuse1))
            || op_stall(near(0, int'(id_a2)), int'(id_tuse2))
            || (id_md_use && busy);
    return e;
  endfunction

  function automatic void model_step(bit st);
    if (reset) begin
      for (int i = 0; i < 3; i++) occ[i] = 1'b0;
      md_free = 0;
    end else begin
      if (occ[0] && pipe[0].md) md_free = cyc + 1 + MD_LAT;
      pipe[2] = pipe[1]; occ[2] = occ[1];
      pipe[1] = pipe[0]; occ[1] = occ[0];
      occ[0] = !st;
      pipe[0].a1 = int'(id_a1); pipe[0].a2 = int'(id_a2); pipe[0].a3 = int'(id_a3);
      pipe[0].tnew = int'(id_tnew); pipe[0].we = id_regwe; pipe[0].md = id_md_start;
    end
    cyc++;
  endfunction

  task automatic drive(input int a1, input int t1, input int a2, input int t2,
                       input int a3, input int tn, input bit we,
                       input bit mu, input bit ms, input bit rst, output bit st);
    exp_t e;
    @(posedge clk);
    #1;
    id_a1 = REG_AW'(a1); id_tuse1 = TW'(t1);
    id_a2 = REG_AW'(a2); id_tuse2 = TW'(t2);
    id_a3 = REG_AW'(a3); id_tnew = TW'(tn); id_regwe = we;
    id_md_use = mu; id_md_start = ms; reset = rst;
    e = model_out();
    exp_q.push_back(e);
    model_step(e.stall);
    st = e.stall;
  endtask

  // Holds an instruction in D until the model predicts it is accepted.
  task automatic issue(input int a1, input int t1, input int a2, input int t2,
                       input int a3, input int tn, input bit we, input bit mu, input bit ms);
    bit st;
    int n;
    n = 0;
    do begin
      drive(a1, t1, a2, t2, a3, tn, we, mu, ms, 1'b0, st);
      n++;
    end while (st && n < 20);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stall", int'(stall), int'(e.stall));
        chk("d1_fw", int'(d1_fw), int'(e.d1));
        chk("d2_fw", int'(d2_fw), int'(e.d2));
        chk("e1_fw", int'(e1_fw), int'(e.e1));
        chk("e2_fw", int'(e2_fw), int'(e.e2));
        chk("m1_fw", int'(m1_fw), int'(e.m1));
        chk("m2_fw", int'(m2_fw), int'(e.m2));
        chk("md_busy", int'(md_busy), int'(e.busy));
      end
    end
  end

  initial begin : stim
    bit st, ms;
    repeat (2) @(posedge clk);
    // empty pipeline read of $1
    issue(1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    // lw $2 ; addu $3,$2,$2 (tuse 1)
    issue(1, 1, 0, 1, 2, 2, 1'b1, 1'b0, 1'b0);
    issue(2, 1, 2, 1, 3, 1, 1'b1, 1'b0, 1'b0);
    nops(3);
    // addu $4 ; beq $4 (tuse 0)
    issue(1, 1, 1, 1, 4, 1, 1'b1, 1'b0, 1'b0);
    issue(4, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    nops(3);
    // two producers of $5, then a $0 producer
    issue(0, 0, 0, 0, 5, 0, 1'b1, 1'b0, 1'b0);
    issue(0, 0, 0, 0, 5, 1, 1'b1, 1'b0, 1'b0);
    nops(1);
    issue(5, 0, 5, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    issue(0, 0, 0, 0, 0, 2, 1'b1, 1'b0, 1'b0);
    issue(0, 0, 0, 0, 6, 1, 1'b1, 1'b0, 1'b0);
    nops(3);
    // mult ; mflo
    issue(1, 1, 2, 1, 0, 0, 1'b0, 1'b1, 1'b1);
    issue(0, 0, 0, 0, 7, 0, 1'b1, 1'b1, 1'b0);
    nops(3);
    // reset with counter at 3 and lw in E
    issue(1, 1, 2, 1, 0, 0, 1'b0, 1'b1, 1'b1);
    nops(2);
    issue(1, 1, 0, 0, 8, 2, 1'b1, 1'b0, 1'b0);
    drive(8, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, st);
    nops(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ms = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
            ms || ($urandom_range(0, 7) == 0), ms, $urandom_range(0, 63) == 0, st);
    end
    repeat (3) @(posedge clk);
    chk("queue_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
